// File: rtl/fp16_addsub_seq_if.sv
// Handshake bundle for fp16_addsub_seq.
//   master : operand issue side / result consumer (drives operands and out_ready)
//   slave  : the add/sub sequencer (drives in_ready, out_valid, result, busy)
// Signals:
//   in_valid/in_ready   operand pair handshake
//   op_a/op_b/add_sub   binary16 operands, 0 = A+B, 1 = A-B
//   out_valid/out_ready result handshake
//   result              binary16 result
//   busy                high whenever the sequencer is not idle
interface fp16_addsub_seq_if #(
   parameter int W = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         add_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         busy;

   modport master (
      output in_valid, op_a, op_b, add_sub, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, op_a, op_b, add_sub, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/fp16_addsub_seq.sv
// Multi-cycle binary16 add/subtract sequencer.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    fp16_addsub_seq_if.slave: operand handshake in, result handshake out
// Subnormal inputs are flushed to zero, alignment and normalisation truncate
// (round toward zero). The signed-magnitude add lives in op_sign_logic.

// Sign/magnitude add or subtract of two hidden-bit mantissas.
//   mant_a/mant_b  aligned mantissas with hidden bit
//   sign_a/sign_b  operand signs, add_sub 0 = A+B, 1 = A-B
//   mantissa_r     magnitude of the result, one carry bit wider
//   sign_r         sign of the result
module op_sign_logic #(
   parameter int MAN_W = 10
) (
   input  logic [MAN_W:0]   mant_a,
   input  logic [MAN_W:0]   mant_b,
   input  logic             sign_a,
   input  logic             sign_b,
   input  logic             add_sub,
   output logic [MAN_W+1:0] mantissa_r,
   output logic             sign_r
);
   logic eff_sub;

   always_comb begin
      eff_sub    = add_sub ^ sign_a ^ sign_b;
      mantissa_r = '0;
      sign_r     = sign_a;
      if (!eff_sub) begin
         mantissa_r = {1'b0, mant_a} + {1'b0, mant_b};
      end else if (mant_a >= mant_b) begin
         mantissa_r = {1'b0, mant_a} - {1'b0, mant_b};
      end else begin
         // B dominates: its effective sign is inverted by a subtract
         mantissa_r = {1'b0, mant_b} - {1'b0, mant_a};
         sign_r     = sign_b ^ add_sub;
      end
   end
endmodule

// state  | meaning
// IDLE   | waiting for an operand pair, in_ready high
// UNPACK | split and classify operands, specials bypass to PACK
// ALIGN  | shift the smaller-exponent mantissa right
// ADD    | capture op_sign_logic magnitude and sign
// NORM   | one normalisation step per cycle
// PACK   | assemble the binary16 result
// DONE   | hold result with out_valid until out_ready
module fp16_addsub_seq #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   fp16_addsub_seq_if.slave   bus
);
   localparam int FP_W = 1 + EXP_W + MAN_W;
   localparam logic [EXP_W-1:0] EXP_MAX   = {EXP_W{1'b1}};
   localparam logic [EXP_W:0]   EXP_INF   = {1'b0, EXP_MAX};
   localparam logic [EXP_W:0]   EXP_ONE   = (EXP_W+1)'(1);
   localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(MAN_W + 1);
   localparam logic [FP_W-1:0]  QNAN      = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNPACK,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_PACK,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [FP_W-1:0]  op_a_r, op_b_r;
   logic             add_sub_r;
   logic             sign_a, sign_b;
   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W:0]   man_a, man_b;
   logic             spec_hit;
   logic [FP_W-1:0]  spec_val;
   logic             sign_w;
   logic [EXP_W:0]   exp_w;
   logic [MAN_W+1:0] mant_w;
   logic [FP_W-1:0]  result_r;

   // classification of the captured operands
   logic             ua_sign, ub_sign;
   logic [EXP_W-1:0] ua_exp, ub_exp;
   logic [MAN_W-1:0] ua_frac, ub_frac;
   logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
   logic             special;
   logic [FP_W-1:0]  special_res;

   always_comb begin
      ua_sign = op_a_r[FP_W-1];
      ub_sign = op_b_r[FP_W-1];
      ua_exp  = op_a_r[FP_W-2 -: EXP_W];
      ub_exp  = op_b_r[FP_W-2 -: EXP_W];
      ua_frac = op_a_r[MAN_W-1:0];
      ub_frac = op_b_r[MAN_W-1:0];
      zero_a  = (ua_exp == '0);
      zero_b  = (ub_exp == '0);
      inf_a   = (ua_exp == EXP_MAX) && (ua_frac == '0);
      inf_b   = (ub_exp == EXP_MAX) && (ub_frac == '0);
      nan_a   = (ua_exp == EXP_MAX) && (ua_frac != '0);
      nan_b   = (ub_exp == EXP_MAX) && (ub_frac != '0);
      special = nan_a | nan_b | inf_a | inf_b | (zero_a & zero_b);

      special_res = '0;
      if (nan_a || nan_b) begin
         special_res = QNAN;
      end else if (inf_a && inf_b) begin
         if (add_sub_r ^ ua_sign ^ ub_sign) special_res = QNAN;
         else special_res = {ua_sign, EXP_MAX, {MAN_W{1'b0}}};
      end else if (inf_a) begin
         special_res = {ua_sign, EXP_MAX, {MAN_W{1'b0}}};
      end else if (inf_b) begin
         special_res = {ub_sign ^ add_sub_r, EXP_MAX, {MAN_W{1'b0}}};
      end else begin
         // both zero: negative only when both effective signs are negative
         special_res = {ua_sign & (ub_sign ^ add_sub_r), {(FP_W-1){1'b0}}};
      end
   end

   // alignment of the smaller-exponent mantissa
   logic             a_ge_b;
   logic [EXP_W-1:0] exp_diff;
   logic [MAN_W:0]   man_small_sh;

   always_comb begin
      a_ge_b   = (exp_a >= exp_b);
      exp_diff = a_ge_b ? (exp_a - exp_b) : (exp_b - exp_a);
      if (exp_diff >= SHIFT_LIM) man_small_sh = '0;
      else man_small_sh = (a_ge_b ? man_b : man_a) >> exp_diff;
   end

   logic [MAN_W+1:0] sum_mant;
   logic             sum_sign;

   op_sign_logic #(.MAN_W(MAN_W)) u_op_sign (
      .mant_a     (man_a),
      .mant_b     (man_b),
      .sign_a     (sign_a),
      .sign_b     (sign_b),
      .add_sub    (add_sub_r),
      .mantissa_r (sum_mant),
      .sign_r     (sum_sign)
   );

   // normalisation step decode
   logic norm_zero, norm_carry, norm_ovf, norm_low, norm_left;

   always_comb begin
      norm_zero  = (mant_w == '0);
      norm_carry = mant_w[MAN_W+1];
      norm_ovf   = (exp_w + EXP_ONE) == EXP_INF;
      norm_low   = !mant_w[MAN_W];
      norm_left  = (exp_w > EXP_ONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (bus.in_valid) state_nxt = S_UNPACK;
         S_UNPACK: state_nxt = special ? S_PACK : S_ALIGN;
         S_ALIGN:  state_nxt = S_ADD;
         S_ADD:    state_nxt = S_NORM;
         S_NORM: begin
            if (norm_zero)       state_nxt = S_PACK;
            else if (norm_carry) state_nxt = norm_ovf ? S_PACK : S_NORM;
            else if (norm_low)   state_nxt = norm_left ? S_NORM : S_PACK;
            else                 state_nxt = S_PACK;
         end
         S_PACK:   state_nxt = S_DONE;
         S_DONE:   if (bus.out_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_a_r    <= '0;
         op_b_r    <= '0;
         add_sub_r <= 1'b0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         exp_a     <= '0;
         exp_b     <= '0;
         man_a     <= '0;
         man_b     <= '0;
         spec_hit  <= 1'b0;
         spec_val  <= '0;
         sign_w    <= 1'b0;
         exp_w     <= '0;
         mant_w    <= '0;
         result_r  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  op_a_r    <= bus.op_a;
                  op_b_r    <= bus.op_b;
                  add_sub_r <= bus.add_sub;
               end
            end
            S_UNPACK: begin
               spec_hit <= special;
               spec_val <= special_res;
               sign_a   <= ua_sign;
               sign_b   <= ub_sign;
               exp_a    <= ua_exp;
               exp_b    <= ub_exp;
               man_a    <= zero_a ? '0 : {1'b1, ua_frac};
               man_b    <= zero_b ? '0 : {1'b1, ub_frac};
            end
            S_ALIGN: begin
               if (a_ge_b) begin
                  man_b <= man_small_sh;
                  exp_w <= {1'b0, exp_a};
               end else begin
                  man_a <= man_small_sh;
                  exp_w <= {1'b0, exp_b};
               end
            end
            S_ADD: begin
               mant_w <= sum_mant;
               sign_w <= sum_sign;
            end
            S_NORM: begin
               if (norm_zero) begin
                  // exact cancellation is always +0
                  sign_w <= 1'b0;
                  exp_w  <= '0;
               end else if (norm_carry) begin
                  exp_w <= exp_w + EXP_ONE;
                  // overflow leaves exp at all-ones with a zero fraction: signed inf
                  mant_w <= norm_ovf ? '0 : (mant_w >> 1);
               end else if (norm_low) begin
                  if (norm_left) begin
                     mant_w <= mant_w << 1;
                     exp_w  <= exp_w - EXP_ONE;
                  end else begin
                     mant_w <= '0;
                     exp_w  <= '0;
                  end
               end
            end
            S_PACK: begin
               result_r <= spec_hit ? spec_val
                                    : {sign_w, exp_w[EXP_W-1:0], mant_w[MAN_W-1:0]};
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.result    = result_r;
endmodule

// File: tb/tb_fp16_addsub_seq.sv
module tb_fp16_addsub_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   fp16_addsub_seq_if #(.W(16)) bus ();

   fp16_addsub_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: decode to integers, do a signed integer sum of the aligned
   // mantissas, then normalise one step per NORM cycle. lat is the number of
   // edges after the accept edge until out_valid is first seen.
   function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                     input logic s, output logic [15:0] r,
                                     output int lat);
      int  ea, eb, fa, fb, ma, mb, va, vb, sum, mag, e, d, nc;
      bit  sa, sb, sbe, nan_a, nan_b, inf_a, inf_b, neg;
      sa = a[15]; sb = b[15];
      ea = int'(a[14:10]); eb = int'(b[14:10]);
      fa = int'(a[9:0]);   fb = int'(b[9:0]);
      sbe   = sb ^ s;
      nan_a = (ea == 31) && (fa != 0);
      nan_b = (eb == 31) && (fb != 0);
      inf_a = (ea == 31) && (fa == 0);
      inf_b = (eb == 31) && (fb == 0);
      lat = 2;
      if (nan_a || nan_b) begin r = 16'h7E00; return; end
      if (inf_a && inf_b) begin
         r = (sa != sbe) ? 16'h7E00 : (sa ? 16'hFC00 : 16'h7C00);
         return;
      end
      if (inf_a) begin r = sa  ? 16'hFC00 : 16'h7C00; return; end
      if (inf_b) begin r = sbe ? 16'hFC00 : 16'h7C00; return; end
      if (ea == 0 && eb == 0) begin r = (sa && sbe) ? 16'h8000 : 16'h0000; return; end
      ma = (ea == 0) ? 0 : 1024 + fa;
      mb = (eb == 0) ? 0 : 1024 + fb;
      if (ea >= eb) begin
         e = ea; d = ea - eb; mb = (d >= 11) ? 0 : (mb >> d);
      end else begin
         e = eb; d = eb - ea; ma = (d >= 11) ? 0 : (ma >> d);
      end
      va  = sa  ? -ma : ma;
      vb  = sbe ? -mb : mb;
      sum = va + vb;
      neg = (sum < 0);
      mag = neg ? -sum : sum;
      nc = 0;
      forever begin
         nc++;
         if (mag == 0) begin r = 16'h0000; break; end
         if (mag >= 2048) begin
            mag = mag / 2; e = e + 1;
            if (e == 31) begin r = neg ? 16'hFC00 : 16'h7C00; break; end
            continue;
         end
         if (mag < 1024) begin
            if (e > 1) begin mag = mag * 2; e = e - 1; continue; end
            r = neg ? 16'h8000 : 16'h0000;
            break;
         end
         r = {neg, 5'(e), 10'(mag % 1024)};
         break;
      end
      lat = 4 + nc;
   endfunction

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input string tag, input bit verbose);
      logic [15:0] er;
      int          el, lat, g;
      ref_model(a, b, s, er, el);
      g = 0;
      while (!bus.in_ready && g < 50) begin @(posedge clk); #1; g++; end
      bus.op_a = a; bus.op_b = b; bus.add_sub = s; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      if (verbose) begin
         chk({tag, "_lat"}, lat, el);
         chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      end else if (lat != el) begin
         chk({tag, "_lat"}, lat, el);
      end
      chk({tag, "_res"}, {16'd0, bus.result}, {16'd0, er});
      if (bus.out_ready) begin
         @(posedge clk); #1;
         if (verbose) chk({tag, "_idle"}, {31'd0, bus.in_ready}, 32'd1);
      end
   endtask

   initial begin
      logic [15:0] ra, rb, held;
      int          seen;
      bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
      bus.add_sub = 1'b0; bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_busy",      {31'd0, bus.busy},      32'd0);
      chk("rst_result",    {16'd0, bus.result},    32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(16'h3C00, 16'h3C00, 1'b0, "one_plus_one", 1'b1);
      chk("one_plus_one_val", {16'd0, bus.result}, 32'h4000);
      do_op(16'h3E00, 16'h3C00, 1'b1, "left_shift", 1'b1);
      chk("left_shift_val", {16'd0, bus.result}, 32'h3800);
      do_op(16'h3C00, 16'h3C00, 1'b1, "cancel", 1'b1);
      do_op(16'h7BFF, 16'h7BFF, 1'b0, "overflow", 1'b1);
      chk("overflow_val", {16'd0, bus.result}, 32'h7C00);
      do_op(16'h7C00, 16'h7C00, 1'b1, "inf_minus_inf", 1'b1);
      chk("inf_minus_inf_val", {16'd0, bus.result}, 32'h7E00);
      do_op(16'h3C00, 16'h1000, 1'b0, "d_eq_11", 1'b1);
      do_op(16'hBC00, 16'h3800, 1'b0, "neg_plus_pos", 1'b1);
      do_op(16'h8000, 16'h8000, 1'b0, "negz_plus_negz", 1'b1);
      do_op(16'h8000, 16'h0000, 1'b1, "negz_minus_posz", 1'b1);
      do_op(16'h0000, 16'h3C00, 1'b1, "zero_minus_one", 1'b1);
      do_op(16'h3C00, 16'h7C00, 1'b1, "fin_minus_inf", 1'b1);
      do_op(16'h0401, 16'h0400, 1'b1, "flush_low", 1'b1);

      // backpressure in DONE
      bus.out_ready = 1'b0;
      do_op(16'h4000, 16'h3C00, 1'b0, "bp", 1'b1);
      held = bus.result;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_result_hold", {16'd0, bus.result},    {16'd0, held});
         chk("bp_valid_hold",  {31'd0, bus.out_valid}, 32'd1);
         chk("bp_in_ready",    {31'd0, bus.in_ready},  32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("bp_release_ready", {31'd0, bus.in_ready},  32'd1);
      chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
      bus.out_ready = 1'b1;

      // reset while normalising a long left-shift sequence
      bus.op_a = 16'h3C01; bus.op_b = 16'h3C00; bus.add_sub = 1'b1; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("abort_pre_valid", {31'd0, bus.out_valid}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("abort_busy",      {31'd0, bus.busy},      32'd0);
      chk("abort_result",    {16'd0, bus.result},    32'd0);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      chk("abort_no_output", seen, 0);

      // randomized operands, biased toward specials and close exponents
      for (int i = 0; i < 400; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         case ($urandom_range(0, 7))
            0: ra[14:10] = 5'h1F;
            1: rb[14:10] = 5'h00;
            2: rb[14:10] = ra[14:10];
            3: begin rb[14:10] = ra[14:10]; rb[9:0] = ra[9:0] ^ 10'($urandom_range(0, 7)); end
            default: ;
         endcase
         do_op(ra, rb, 1'($urandom_range(0, 1)), "rand", 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
